// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw button input and conditioned outputs of one debounced pushbutton
interface btn_debounce_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic hold_sig;
  modport master (output btn_in, input btn_level, press_pulse, release_pulse, hold_sig);
  modport slave (input btn_in, output btn_level, press_pulse, release_pulse, hold_sig);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise, debounce and classify an active-low pushbutton.
// Long-press timing (HELD state, hold_sig) is compiled in only with BTN_DEBOUNCE_HOLD_EN.
module btn_debounce #(
  parameter logic [23:0] DEBOUNCE_COUNT = 24'd500000,
  parameter logic [23:0] HOLD_COUNT = 24'd12500000
) (
  input logic clk,
  input logic rst_btn,
  btn_debounce_if.slave b
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRESS_WAIT = 3'd1,
    PRESSED = 3'd2,
    HELD = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;
  state_t state, state_n;
  logic s1, s2;
  logic [23:0] cnt, cnt_n;
  logic level, level_n, press, press_n, rel, rel_n;
  logic pressed_raw, hit_db;
`ifdef BTN_DEBOUNCE_HOLD_EN
  logic hold, hold_n, was_held, held_n;
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_COUNT;
`endif
  assign pressed_raw = ~s2;
  assign hit_db = cnt == DEBOUNCE_COUNT - 24'd1;
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
`ifdef BTN_DEBOUNCE_HOLD_EN
      hold <= 1'b0;
      was_held <= 1'b0;
`endif
    end else begin
      s1 <= b.btn_in;
      s2 <= s1;
      state <= state_n;
      cnt <= cnt_n;
      level <= level_n;
      press <= press_n;
      rel <= rel_n;
`ifdef BTN_DEBOUNCE_HOLD_EN
      hold <= hold_n;
      was_held <= held_n;
`endif
    end
  end
  // the counter is shared, so any state change restarts it from zero
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    level_n = level;
    press_n = 1'b0;
    rel_n = 1'b0;
`ifdef BTN_DEBOUNCE_HOLD_EN
    hold_n = hold;
    held_n = was_held;
`endif
    case (state)
      IDLE: state_n = pressed_raw ? PRESS_WAIT : IDLE;
      PRESS_WAIT:
        if (!pressed_raw) state_n = IDLE;
        else if (hit_db) begin
          state_n = PRESSED;
          level_n = 1'b1;
          press_n = 1'b1;
        end else cnt_n = cnt + 24'd1;
`ifdef BTN_DEBOUNCE_HOLD_EN
      PRESSED:
        if (!pressed_raw) state_n = RELEASE_WAIT;
        else if (cnt == HOLD_COUNT - 24'd1) begin
          state_n = HELD;
          hold_n = 1'b1;
          held_n = 1'b1;
        end else cnt_n = cnt + 24'd1;
      HELD: state_n = pressed_raw ? HELD : RELEASE_WAIT;
`else
      PRESSED: state_n = pressed_raw ? PRESSED : RELEASE_WAIT;
`endif
      RELEASE_WAIT:
        if (pressed_raw) begin
`ifdef BTN_DEBOUNCE_HOLD_EN
          state_n = was_held ? HELD : PRESSED;
`else
          state_n = PRESSED;
`endif
        end else if (hit_db) begin
          state_n = IDLE;
          level_n = 1'b0;
          rel_n = 1'b1;
`ifdef BTN_DEBOUNCE_HOLD_EN
          hold_n = 1'b0;
          held_n = 1'b0;
`endif
        end else cnt_n = cnt + 24'd1;
      default: begin
        state_n = IDLE;
        level_n = 1'b0;
`ifdef BTN_DEBOUNCE_HOLD_EN
        hold_n = 1'b0;
        held_n = 1'b0;
`endif
      end
    endcase
    if (state_n != state) cnt_n = '0;
  end
  assign b.btn_level = level;
  assign b.press_pulse = press;
  assign b.release_pulse = rel;
`ifdef BTN_DEBOUNCE_HOLD_EN
  assign b.hold_sig = hold;
`else
  assign b.hold_sig = 1'b0;
`endif
endmodule
